bit32_logic_pipe: RTL and testbench

BIT32_LOGIC_PIPE -- requirements
Module: bit32_logic_pipe

---
 rtl/bit32_logic_pipe.sv | 131 +++++++++++++
 tb/tb_bit32_logic_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit32_logic_pipe.sv
// Two-stage valid/ready pipeline computing a bitwise AND/OR/XOR/NOR of two
// operands. S1 captures the operands, S2 holds the result, its zero flag and
// the op that produced it. Back-pressure ripples combinationally from
// out_ready to in_ready so a full pipe still moves one result per cycle.
module bit32_logic_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic [1:0]       out_op,
  output logic [7:0]       txn_count
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  logic             s1_v_q,   s1_v_d;
  logic [WIDTH-1:0] s1_a_q,   s1_a_d;
  logic [WIDTH-1:0] s1_b_q,   s1_b_d;
  logic [1:0]       s1_op_q,  s1_op_d;
  logic             s2_v_q,   s2_v_d;
  logic [WIDTH-1:0] s2_res_q, s2_res_d;
  logic             s2_zero_q, s2_zero_d;
  logic [1:0]       s2_op_q,  s2_op_d;
  logic [7:0]       txn_q,    txn_d;

  logic             adv1;
  logic             adv2;
  logic [WIDTH-1:0] s1_res;

  // Stage advance enables; a stage may load whenever it is empty or its
  // successor is draining this cycle.
  always_comb begin
    adv2 = !s2_v_q || out_ready;
    adv1 = !s1_v_q || adv2;
  end

  // Bitwise operation on the S1 operands; zero is derived here so S2 only
  // ever stores it, never recomputes it from out.
  always_comb begin
    unique case (s1_op_q)
      OP_AND:  s1_res = s1_a_q & s1_b_q;
      OP_OR:   s1_res = s1_a_q | s1_b_q;
      OP_XOR:  s1_res = s1_a_q ^ s1_b_q;
      default: s1_res = ~(s1_a_q | s1_b_q);
    endcase
  end

  // Next-state for both stages and the transfer counter.
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_op_d   = s1_op_q;
    s2_v_d    = s2_v_q;
    s2_res_d  = s2_res_q;
    s2_zero_d = s2_zero_q;
    s2_op_d   = s2_op_q;
    txn_d     = txn_q;

    if (adv1) begin
      s1_v_d = in_valid;
      // Operands are only sampled with a valid pair so idle bus values never
      // reach the datapath.
      if (in_valid) begin
        s1_a_d  = in1;
        s1_b_d  = in2;
        s1_op_d = op;
      end
    end

    if (adv2) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_res_d  = s1_res;
        s2_zero_d = (s1_res == '0);
        s2_op_d   = s1_op_q;
      end
    end

    if (s2_v_q && out_ready) begin
      txn_d = txn_q + 8'd1;
    end
  end

  // State registers with synchronous reset; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_op_q   <= 2'b00;
      s2_v_q    <= 1'b0;
      s2_res_q  <= '0;
      s2_zero_q <= 1'b0;
      s2_op_q   <= 2'b00;
      txn_q     <= 8'd0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_op_q   <= s1_op_d;
      s2_v_q    <= s2_v_d;
      s2_res_q  <= s2_res_d;
      s2_zero_q <= s2_zero_d;
      s2_op_q   <= s2_op_d;
      txn_q     <= txn_d;
    end
  end

  // Output view of S2.
  always_comb begin
    in_ready  = adv1;
    out_valid = s2_v_q;
    out       = s2_res_q;
    zero      = s2_zero_q;
    out_op    = s2_op_q;
    txn_count = txn_q;
  end

endmodule

// File: tb/tb_bit32_logic_pipe.sv
// Bench for bit32_logic_pipe: directed scenarios followed by a long random
// valid/ready run, all scored against a queue-based transaction model.
module tb_bit32_logic_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        zero;
  logic [1:0]  out_op;
  logic [7:0]  txn_count;

  bit32_logic_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero),
    .out_op    (out_op),
    .txn_count (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [1:0]  op;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  cnt;
  int          tests;
  int          fails;
  int          n_in;
  int          n_out;
  logic        stalled;
  logic [31:0] p_out;
  logic        p_zero;
  logic [1:0]  p_op;

  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] o);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the cycle at the negedge, then advance to just past posedge.
  task automatic step();
    exp_t e;
    logic in_x;
    logic out_x;
    @(negedge clk);
    if (rst) begin
      q.delete();
      cnt     = 8'd0;
      stalled = 1'b0;
    end else begin
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      chk("txn_count", txn_count, cnt);
      chk("no_spurious", out_valid && (q.size() == 0), 1'b0);
      if (stalled) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_out", out, p_out);
        chk("stall_zero", zero, p_zero);
        chk("stall_op", out_op, p_op);
      end
      if (out_valid && q.size() != 0) begin
        chk("out", out, q[0].res);
        chk("zero", zero, q[0].res == 32'd0);
        chk("out_op", out_op, q[0].op);
      end
      in_x    = in_valid && in_ready;
      out_x   = out_valid && out_ready;
      stalled = out_valid && !out_ready;
      p_out   = out;
      p_zero  = zero;
      p_op    = out_op;
      if (out_x && q.size() != 0) begin
        void'(q.pop_front());
        cnt = cnt + 8'd1;
        n_out++;
      end
      if (in_x) begin
        e.res = ref_res(in1, in2, op);
        e.op  = op;
        q.push_back(e);
        n_in++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    int start_out;
    int start_in;
    logic [7:0] start_txn;
    tests = 0; fails = 0; n_in = 0; n_out = 0;
    cnt = 8'd0; stalled = 1'b0;
    p_out = '0; p_zero = 1'b0; p_op = 2'b00;
    rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; op = 2'b00; out_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out", out, 32'd0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_out_op", out_op, 2'b00);
    chk("rst_txn", txn_count, 8'd0);
    rst = 1'b0;

    // AND giving zero; latency check
    in_valid = 1'b1; in1 = 32'h0000A5A5; in2 = 32'h00005A5A; op = 2'b00;
    step();
    chk("lat_not_yet", out_valid, 1'b0);
    in_valid = 1'b0; in1 = $urandom; in2 = $urandom; op = 2'(($urandom));
    step();
    chk("lat_valid", out_valid, 1'b1);
    chk("and_out", out, 32'h00000000);
    chk("and_zero", zero, 1'b1);
    step();

    // OR, XOR, NOR back-to-back
    in_valid = 1'b1; in1 = 32'h0000A5A5; in2 = 32'h00005A5A;
    op = 2'b01; step();
    op = 2'b10; step();
    chk("or_out", out, 32'h0000FFFF); chk("or_zero", zero, 1'b0); chk("or_op", out_op, 2'b01);
    op = 2'b11; step();
    chk("xor_out", out, 32'h0000FFFF); chk("xor_zero", zero, 1'b0); chk("xor_op", out_op, 2'b10);
    in_valid = 1'b0; step();
    chk("nor_out", out, 32'hFFFF0000); chk("nor_zero", zero, 1'b0); chk("nor_op", out_op, 2'b11);
    drain();

    // Stall with three inputs offered
    start_in = n_in;
    out_ready = 1'b0; in_valid = 1'b1;
    in1 = 32'h12345678; in2 = 32'h0F0F0F0F; op = 2'b00; step();
    in1 = 32'hDEADBEEF; in2 = 32'hFFFF0000; op = 2'b10; step();
    chk("stall_in_ready", in_ready, 1'b0);
    in1 = 32'hCAFEF00D; in2 = 32'h00000000; op = 2'b11; step(); step(); step();
    chk("stall_in_ready2", in_ready, 1'b0);
    chk("stall_accepted", n_in - start_in, 2);
    out_ready = 1'b1; step();
    in_valid = 1'b0;
    drain();

    // 256 output transfers wrap txn_count
    start_txn = txn_count;
    start_out = n_out;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 300 && (n_out - start_out) < 256; i++) begin
      in1 = $urandom; in2 = $urandom; op = 2'($urandom);
      if (n_out - start_out >= 254) in_valid = 1'b0;
      step();
    end
    chk("wrap_count", n_out - start_out, 256);
    chk("txn_wrap", txn_count, start_txn);
    drain();

    // Reset with both stages full
    out_ready = 1'b0; in_valid = 1'b1;
    in1 = 32'h11111111; in2 = 32'h22222222; op = 2'b01; step();
    in1 = 32'h33333333; in2 = 32'h44444444; op = 2'b10; step();
    chk("full_before_rst", out_valid, 1'b1);
    rst = 1'b1; in1 = 32'h55555555; step();
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_txn", txn_count, 8'd0);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("no_stale", out_valid, 1'b0);

    // Random valid/ready traffic
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in1 = $urandom;
      op  = 2'($urandom);
      case ($urandom_range(0, 7))
        0:       in2 = in1;
        1:       in2 = ~in1;
        default: in2 = $urandom;
      endcase
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
